// File: rtl/vending_pkg.sv
// Shared types and helpers for the parametrised vending controller.
// State encoding, price-table lookup and one-hot request check.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam int TBL_MAX = 512;
  localparam int VAL_MAX = 32;
  localparam int VEC_MAX = 64;

  // Price of entry k in a flat table of w-bit fields, zero-extended.
  function automatic logic [VAL_MAX-1:0] price_at(
    input logic [TBL_MAX-1:0] tbl,
    input int                 k,
    input int                 w
  );
    logic [TBL_MAX-1:0] sh;
    logic [VAL_MAX-1:0] mask;
    sh = tbl >> (k * w);
    if (w >= VAL_MAX)
      mask = '1;
    else
      mask = (VAL_MAX'(1) << w) - VAL_MAX'(1);
    return sh[VAL_MAX-1:0] & mask;
  endfunction

  // True when exactly one request bit is set.
  function automatic logic is_onehot(
    input logic [VEC_MAX-1:0] v
  );
    return $onehot(v);
  endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Inactivity counter for the coin-collection phase.
// Holds at its terminal count, where expire is raised.
module vend_timeout_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rnot,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW =
    (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LAST =
    TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] count;

  assign expire = (count == LAST);

  // Count idle cycles; clear restarts the window.
  always_ff @(posedge clk or negedge rnot) begin
    if (!rnot)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && !expire)
      count <= count + TW'(1);
  end

endmodule

// File: rtl/vending_controller_n.sv
// NUM_PROD-product vending controller: credit, dispense,
// change and refund on cancel or inactivity timeout.
module vending_controller_n
  import vending_pkg::*;
#(
  parameter  int NUM_PROD    = 4,
  localparam int SEL_W       = $clog2(NUM_PROD),
  parameter  int COIN_W      = 4,
  parameter  int CREDIT_W    = 8,
  parameter  logic [NUM_PROD*CREDIT_W-1:0] PRICES =
    {8'd15, 8'd8, 8'd10, 8'd12},
  parameter  int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rnot,
  input  logic [NUM_PROD-1:0] sel,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_val,
  input  logic                cancel,
  output logic [NUM_PROD-1:0] dispense,
  output logic [SEL_W-1:0]    selection,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic                busy
);

  state_t              state;
  logic [CREDIT_W-1:0] price_tbl [NUM_PROD];
  logic [CREDIT_W-1:0] price_sel;
  logic [SEL_W-1:0]    sel_idx;
  logic                sel_ok;
  logic [NUM_PROD-1:0] sel_hot;
  logic [CREDIT_W:0]   sum_ext;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] remain;
  logic                fits;
  logic                accept;
  logic                quit;
  logic                tmo;
  logic                tmr_clr;
  logic                tmr_en;

  if (NUM_PROD < 2) begin : g_bad_np
    $error("NUM_PROD must be at least 2");
  end

  if (COIN_W > CREDIT_W) begin : g_bad_cw
    $error("COIN_W must not exceed CREDIT_W");
  end

  if (NUM_PROD * CREDIT_W > TBL_MAX) begin : g_bad_tbl
    $error("price table too wide");
  end

  for (genvar k = 0; k < NUM_PROD; k++) begin : g_price
    assign price_tbl[k] = CREDIT_W'(
      price_at(TBL_MAX'(PRICES), k, CREDIT_W));
    if (PRICES[k*CREDIT_W +: CREDIT_W] == '0)
    begin : g_zero
      $error("every product price must be nonzero");
    end
  end

  // Decode the request vector into an index.
  always_comb begin
    sel_ok  = is_onehot(VEC_MAX'(sel));
    sel_idx = '0;
    for (int k = 0; k < NUM_PROD; k++)
      if (sel[k])
        sel_idx = SEL_W'(k);
  end

  // Price and one-hot strobe for the latched product.
  always_comb begin
    price_sel = '0;
    sel_hot   = '0;
    for (int k = 0; k < NUM_PROD; k++)
      if (selection == SEL_W'(k)) begin
        price_sel  = price_tbl[k];
        sel_hot[k] = 1'b1;
      end
  end

  // Coin acceptance, cancel/timeout and remainder.
  always_comb begin
    sum_ext = {1'b0, credit} + (CREDIT_W+1)'(coin_val);
    fits    = !sum_ext[CREDIT_W];
    sum     = sum_ext[CREDIT_W-1:0];
    accept  = (state == COLLECT) && coin_valid
              && !cancel && fits;
    quit    = (state == COLLECT)
              && (cancel || (tmo && !accept));
    remain  = credit - price_sel;
    tmr_clr = (state != COLLECT) || accept;
    tmr_en  = (state == COLLECT);
  end

  vend_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmr (
    .clk   (clk),
    .rnot  (rnot),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(tmo)
  );

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk or negedge rnot) begin
    if (!rnot) begin
      state        <= IDLE;
      credit       <= '0;
      selection    <= '0;
      dispense     <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      dispense     <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= coin_valid && !accept;
      unique case (state)
        IDLE: begin
          if (sel_ok) begin
            selection <= sel_idx;
            state     <= COLLECT;
            busy      <= 1'b1;
          end
        end
        COLLECT: begin
          if (quit) begin
            if (credit != '0) begin
              state        <= CHANGE;
              change_valid <= 1'b1;
              change_amt   <= credit;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              selection <= '0;
            end
          end else if (accept) begin
            credit <= sum;
            if (sum >= price_sel) begin
              state    <= DISPENSE;
              dispense <= sel_hot;
            end
          end
        end
        DISPENSE: begin
          credit <= remain;
          if (remain != '0) begin
            state        <= CHANGE;
            change_valid <= 1'b1;
            change_amt   <= remain;
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            selection <= '0;
          end
        end
        CHANGE: begin
          credit    <= '0;
          state     <= IDLE;
          busy      <= 1'b0;
          selection <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_controller_n.sv
// Directed and randomized checks for vending_controller_n.
// Expected values come from a transaction-level credit model.
module tb_vending_controller_n;

  localparam int NP = 4;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       rnot = 1'b0;

  logic [3:0] sel;
  logic       coin_valid;
  logic [3:0] coin_val;
  logic       cancel;
  logic [3:0] dispense;
  logic [1:0] selection;
  logic [7:0] credit;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       coin_reject;
  logic       busy;

  logic [3:0] sel2;
  logic       cv2;
  logic [3:0] cval2;
  logic       cancel2;
  logic [3:0] dispense2;
  logic [1:0] selection2;
  logic [3:0] credit2;
  logic       change_valid2;
  logic [3:0] change_amt2;
  logic       coin_reject2;
  logic       busy2;

  int nchk = 0;
  int nerr = 0;
  int price_tbl [NP] = '{12, 10, 8, 15};

  always #5 clk = ~clk;

  vending_controller_n u_dut (
    .clk         (clk),
    .rnot        (rnot),
    .sel         (sel),
    .coin_valid  (coin_valid),
    .coin_val    (coin_val),
    .cancel      (cancel),
    .dispense    (dispense),
    .selection   (selection),
    .credit      (credit),
    .change_valid(change_valid),
    .change_amt  (change_amt),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  vending_controller_n #(
    .CREDIT_W(4),
    .PRICES  (16'hFFFF)
  ) u_small (
    .clk         (clk),
    .rnot        (rnot),
    .sel         (sel2),
    .coin_valid  (cv2),
    .coin_val    (cval2),
    .cancel      (cancel2),
    .dispense    (dispense2),
    .selection   (selection2),
    .credit      (credit2),
    .change_valid(change_valid2),
    .change_amt  (change_amt2),
    .coin_reject (coin_reject2),
    .busy        (busy2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] s,
                        input logic cv,
                        input logic [3:0] v,
                        input logic cn);
    sel        = s;
    coin_valid = cv;
    coin_val   = v;
    cancel     = cn;
  endtask

  task automatic set2(input logic [3:0] s,
                      input logic cv,
                      input logic [3:0] v,
                      input logic cn);
    sel2    = s;
    cv2     = cv;
    cval2   = v;
    cancel2 = cn;
  endtask

  initial begin
    int         n;
    int         p;
    int         price;
    int         cr;
    int         chg;
    int         r;
    int         v;
    bit         cv;
    bit         done;
    logic [3:0] bad;

    set_in(4'd0, 1'b0, 4'd0, 1'b0);
    set2(4'd0, 1'b0, 4'd0, 1'b0);
    rnot = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_sel", 32'(selection), 0);
    chk("rst_disp", 32'(dispense), 0);
    chk("rst_cv", 32'(change_valid), 0);
    chk("rst_camt", 32'(change_amt), 0);
    chk("rst_rej", 32'(coin_reject), 0);
    rnot = 1'b1;
    step();

    // 1: price 10, coins 5+5, exact payment
    set_in(4'b0010, 1'b0, 4'd0, 1'b0);
    step();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_sel", 32'(selection), 1);
    set_in(4'd0, 1'b1, 4'd5, 1'b0);
    step();
    chk("t1_cr5", 32'(credit), 5);
    chk("t1_nodisp", 32'(dispense), 0);
    step();
    chk("t1_cr10", 32'(credit), 10);
    chk("t1_disp", 32'(dispense), 4'b0010);
    set_in(4'd0, 1'b0, 4'd0, 1'b0);
    step();
    chk("t1_disp_off", 32'(dispense), 0);
    chk("t1_nochg", 32'(change_valid), 0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_cr0", 32'(credit), 0);

    // 2: price 12, coins 9+9, change 6
    set_in(4'b0001, 1'b0, 4'd0, 1'b0);
    step();
    set_in(4'd0, 1'b1, 4'd9, 1'b0);
    step();
    chk("t2_cr9", 32'(credit), 9);
    step();
    chk("t2_disp", 32'(dispense), 4'b0001);
    set_in(4'd0, 1'b0, 4'd0, 1'b0);
    step();
    chk("t2_cv", 32'(change_valid), 1);
    chk("t2_camt", 32'(change_amt), 6);
    chk("t2_disp_off", 32'(dispense), 0);
    step();
    chk("t2_cr0", 32'(credit), 0);
    chk("t2_cv_off", 32'(change_valid), 0);
    chk("t2_camt0", 32'(change_amt), 0);
    chk("t2_idle", 32'(busy), 0);

    // 3: price 15, coin 7, cancel beats coin
    set_in(4'b1000, 1'b0, 4'd0, 1'b0);
    step();
    chk("t3_sel", 32'(selection), 3);
    set_in(4'd0, 1'b1, 4'd7, 1'b0);
    step();
    chk("t3_cr7", 32'(credit), 7);
    set_in(4'd0, 1'b1, 4'd3, 1'b1);
    step();
    chk("t3_cv", 32'(change_valid), 1);
    chk("t3_camt", 32'(change_amt), 7);
    chk("t3_rej", 32'(coin_reject), 1);
    chk("t3_nodisp", 32'(dispense), 0);
    set_in(4'd0, 1'b0, 4'd0, 1'b0);
    step();
    chk("t3_idle", 32'(busy), 0);
    chk("t3_cr0", 32'(credit), 0);

    // 4: multi-bit sel ignored, then timeout refund
    set_in(4'b0011, 1'b0, 4'd0, 1'b0);
    step();
    chk("t4_ignored", 32'(busy), 0);
    set_in(4'b0100, 1'b0, 4'd0, 1'b0);
    step();
    chk("t4_sel", 32'(selection), 2);
    set_in(4'd0, 1'b1, 4'd3, 1'b0);
    step();
    chk("t4_cr3", 32'(credit), 3);
    set_in(4'd0, 1'b0, 4'd0, 1'b0);
    n = 0;
    for (int i = 0; i < 2 * TO; i++) begin
      step();
      n++;
      if (change_valid) break;
    end
    chk("t4_tmo_cycles", 32'(n), TO);
    chk("t4_camt", 32'(change_amt), 3);
    step();
    chk("t4_idle", 32'(busy), 0);

    // 5a: coin while idle is rejected
    set_in(4'd0, 1'b1, 4'd5, 1'b0);
    step();
    chk("t5_rej", 32'(coin_reject), 1);
    chk("t5_cr0", 32'(credit), 0);
    chk("t5_idle", 32'(busy), 0);
    set_in(4'd0, 1'b0, 4'd0, 1'b0);
    step();
    chk("t5_rej_off", 32'(coin_reject), 0);

    // 5b: 4-bit credit saturation guard
    set2(4'b0001, 1'b0, 4'd0, 1'b0);
    step();
    set2(4'd0, 1'b1, 4'd7, 1'b0);
    step();
    step();
    chk("t5_small_cr14", 32'(credit2), 14);
    set2(4'd0, 1'b1, 4'd3, 1'b0);
    step();
    chk("t5_small_rej", 32'(coin_reject2), 1);
    chk("t5_small_cr", 32'(credit2), 14);
    chk("t5_small_nodisp", 32'(dispense2), 0);
    set2(4'd0, 1'b0, 4'd0, 1'b1);
    step();
    chk("t5_small_camt", 32'(change_amt2), 14);
    set2(4'd0, 1'b0, 4'd0, 1'b0);
    step();
    chk("t5_small_idle", 32'(busy2), 0);

    // 6: asynchronous reset mid-transaction
    set_in(4'b0001, 1'b0, 4'd0, 1'b0);
    step();
    set_in(4'd0, 1'b1, 4'd9, 1'b0);
    step();
    chk("t6_cr9", 32'(credit), 9);
    set_in(4'd0, 1'b0, 4'd0, 1'b0);
    #1;
    rnot = 1'b0;
    #1;
    chk("t6_async_cr", 32'(credit), 0);
    chk("t6_async_busy", 32'(busy), 0);
    chk("t6_async_sel", 32'(selection), 0);
    chk("t6_async_cv", 32'(change_valid), 0);
    step();
    rnot = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_refund", 32'(change_valid), 0);
      chk("t6_idle", 32'(busy), 0);
    end

    // Randomized transactions against the credit model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        do bad = 4'($urandom_range(0, 15));
        while ($countones(bad) == 1);
        set_in(bad, 1'b0, 4'd0, 1'b0);
        step();
        chk("rnd_bad_sel", 32'(busy), 0);
      end
      p     = $urandom_range(0, NP - 1);
      price = price_tbl[p];
      set_in(4'(1 << p), 1'b0, 4'd0, 1'b0);
      step();
      chk("rnd_busy", 32'(busy), 1);
      chk("rnd_sel", 32'(selection), 32'(p));
      cr   = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        r = $urandom_range(0, 19);
        v = $urandom_range(0, 15);
        if (r == 0) begin
          cv = 1'($urandom_range(0, 1));
          set_in(4'd0, cv, 4'(v), 1'b1);
          step();
          chk("rnd_cn_rej", 32'(coin_reject), 32'(cv));
          chk("rnd_cn_disp", 32'(dispense), 0);
          if (cr > 0) begin
            chk("rnd_cn_cv", 32'(change_valid), 1);
            chk("rnd_cn_amt", 32'(change_amt), 32'(cr));
            chk("rnd_cn_cr", 32'(credit), 32'(cr));
            set_in(4'd0, 1'b0, 4'd0, 1'b0);
            step();
          end else begin
            chk("rnd_cn_nocv", 32'(change_valid), 0);
          end
          done = 1'b1;
        end else if (r < 5) begin
          set_in(4'd0, 1'b0, 4'd0, 1'b0);
          step();
          chk("rnd_hold_cr", 32'(credit), 32'(cr));
          chk("rnd_hold_rej", 32'(coin_reject), 0);
        end else begin
          set_in(4'd0, 1'b1, 4'(v), 1'b0);
          step();
          cr += v;
          chk("rnd_cr", 32'(credit), 32'(cr));
          chk("rnd_rej", 32'(coin_reject), 0);
          if (cr >= price) begin
            chk("rnd_disp", 32'(dispense), 32'(1 << p));
            set_in(4'd0, 1'b0, 4'd0, 1'b0);
            step();
            chk("rnd_disp_off", 32'(dispense), 0);
            chg = cr - price;
            if (chg > 0) begin
              chk("rnd_chg_cv", 32'(change_valid), 1);
              chk("rnd_chg_amt", 32'(change_amt),
                  32'(chg));
              step();
            end else begin
              chk("rnd_nochg", 32'(change_valid), 0);
            end
            done = 1'b1;
          end else begin
            chk("rnd_nodisp", 32'(dispense), 0);
          end
        end
      end
      set_in(4'd0, 1'b0, 4'd0, 1'b0);
      chk("rnd_txn_done", 32'(done), 1);
      if (!done) begin
        rnot = 1'b0;
        #1;
        rnot = 1'b1;
      end
      chk("rnd_end_busy", 32'(busy), 0);
      chk("rnd_end_cr", 32'(credit), 0);
      chk("rnd_end_cv", 32'(change_valid), 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/vending_controller_n.md
Name: vending_controller_n

Overview:
Parametrised successor to the two-product vending controller. It supports NUM_PROD products, each with its own price from a parameter table. Credit accumulates from coins delivered one per cycle. On purchase it dispenses and returns change; cancel and an inactivity timeout both refund the credit. It sits between the coin/keypad front end and the dispenser/change mechanism.

Parameters:
NUM_PROD, 4, number of products; must be >= 2.
SEL_W, $clog2(NUM_PROD), width of the selection index; derived, never overridden.
COIN_W, 4, width of one coin value.
CREDIT_W, 8, width of the credit accumulator and of change_amt.
PRICES, {8'd15,8'd8,8'd10,8'd12}, flat price table; product k's price is PRICES[k*CREDIT_W +: CREDIT_W]. Every price must be nonzero and is checked at elaboration.
TIMEOUT_CYC, 255, number of cycles in COLLECT with no accepted coin before an automatic refund.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rnot  in  1  asynchronous active-low reset.
sel  in  NUM_PROD  product request bits; sampled only in IDLE.
coin_valid  in  1  one coin is presented this cycle.
coin_val  in  COIN_W  value of the presented coin.
cancel  in  1  refund request.
dispense  out  NUM_PROD  one-hot, one-cycle dispense strobe.
selection  out  SEL_W  index of the latched product.
credit  out  CREDIT_W  current accumulated credit.
change_valid  out  1  one-cycle strobe; change_amt is valid while it is high.
change_amt  out  CREDIT_W  change or refund value.
coin_reject  out  1  one-cycle strobe: the previous cycle's coin was not accepted.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rnot=0), applied immediately and asynchronously, including mid-transaction: state=IDLE, credit=0, selection=0, timer=0, and dispense, change_valid, change_amt, coin_reject all 0. Any transaction in progress is lost; no refund is issued.
- States: IDLE, COLLECT, DISPENSE, CHANGE. All outputs are registered.
- IDLE:
  - If sel has exactly one bit set, latch its index into selection; go to COLLECT next cycle.
  - sel with zero bits or more than one bit set is ignored.
  - A coin in IDLE is rejected: coin_reject=1 in the next cycle, credit stays 0.
- COLLECT:
  - Coin acceptance: a coin is accepted when coin_valid=1, cancel=0, and credit+coin_val <= 2^CREDIT_W-1. An accepted coin sets credit <= credit+coin_val.
  - A coin that is not accepted is rejected (coin_reject pulse next cycle, credit unchanged).
  - If cancel and coin_valid arrive together, cancel wins and the coin is rejected.
  - Purchase: if the post-update credit is >= the selected product's price, go to DISPENSE. Latency: dispense is high in the cycle immediately after the clock edge that accepted the qualifying coin.
  - Cancel: go to CHANGE if credit > 0, otherwise go to IDLE.
  - Timer: cleared on entry to COLLECT and on every accepted coin; otherwise increments each cycle. When the timer reaches TIMEOUT_CYC-1 without an accepted coin, behave exactly as for cancel.
  - sel is ignored in COLLECT; the selection cannot change mid-transaction.
- DISPENSE (exactly 1 cycle):
  - dispense[selection]=1; credit <= credit - price.
  - Next state is CHANGE if the remainder is > 0, otherwise IDLE.
- CHANGE (exactly 1 cycle):
  - change_valid=1, change_amt=credit; credit <= 0; next state IDLE.
  - change_amt reads 0 whenever change_valid=0.
- Coins arriving in DISPENSE or CHANGE are rejected.
- selection holds its value until the return to IDLE, then resets to 0.
- Arithmetic: unsigned, CREDIT_W bits wide. The subtraction in DISPENSE cannot underflow because DISPENSE is only entered when credit >= price.

Decomposition:
- Package vending_pkg holds:
  - the state enum (IDLE=2'd0, COLLECT=2'd1, DISPENSE=2'd2, CHANGE=2'd3);
  - a function that returns the price of index k from the flat table;
  - a one-hot-valid check function.
- One sub-module, vend_timeout_timer: a $clog2(TIMEOUT_CYC)-bit counter with a clear input, an enable input and an expire output, reset by rnot.

Test Plan:
1. Default parameters. sel=4'b0010 (price 10), coins 5 then 5 -> credit 5 then 10; dispense=4'b0010 for one cycle after the second coin; no change_valid; busy drops the following cycle.
2. sel=4'b0001 (price 12), coins 9 then 9 -> dispense=4'b0001, then the next cycle change_valid=1 with change_amt=6; credit=0 afterwards.
3. sel=4'b1000 (price 15), coin 7, then cancel with a coin of 3 in the same cycle -> change_valid=1 with change_amt=7, coin_reject=1, dispense never asserts.
4. sel=4'b0011 -> ignored, busy stays 0. Then sel=4'b0100, coin 3, no further activity for TIMEOUT_CYC cycles -> refund change_amt=3, then IDLE.
5. Coin 5 in IDLE -> coin_reject=1, credit=0. With CREDIT_W=4 and PRICES all 4'd15: credit 14 plus coin 3 -> coin is rejected and credit stays 14.
6. rnot pulsed low in COLLECT with credit 9 -> all outputs 0 immediately, without waiting for a clock edge; after release the block sits in IDLE and no refund strobe appears.
